// File: rtl/shift_executor.sv
// Multi-cycle shift/rotate unit on the receiving end of the ALU control
// decoder's shifter command stream. An operand is loaded into the shift
// register, then shifted or rotated one bit per clock. The final value drives
// the ALUOut mux (select 2'b10).
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-low; clears all state immediately
//   SHIFTER_control  command: 000 nop, 001 load, 010 sll, 011 srl, 100 sra,
//                    101 rotr, 110 rotl, 111 reserved (flagged)
//   M_SHIFTER        0: load src_a / amount=shamt; 1: load src_b / amount=LUI_AMT
//   src_a            register operand
//   src_b            zero-extended immediate operand
//   shamt            shift amount, sampled when a shift command is accepted
//   result           shift register contents
//   busy             high while a shift is in progress
//   done             one-cycle pulse when a shift completes
//   illegal_cmd      one-cycle pulse when the reserved code is seen in IDLE
module shift_executor #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned LUI_AMT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         SHIFTER_control,
  input  logic               M_SHIFTER,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic               done,
  output logic               illegal_cmd
);

  localparam logic [2:0] CMD_NOP  = 3'b000;
  localparam logic [2:0] CMD_LOAD = 3'b001;
  localparam logic [2:0] CMD_SLL  = 3'b010;
  localparam logic [2:0] CMD_SRL  = 3'b011;
  localparam logic [2:0] CMD_SRA  = 3'b100;
  localparam logic [2:0] CMD_ROTR = 3'b101;
  localparam logic [2:0] CMD_ROTL = 3'b110;
  localparam logic [2:0] CMD_ILL  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [2:0]         op_q, op_d;
  logic [2:0]         prev_cmd_q;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               illegal_q, illegal_d;

  logic               is_shift_c;
  logic               accept_c;
  logic [SHAMT_W-1:0] amount_c;

  // A shift code is only accepted on a change of level, so a held command
  // never re-executes.
  assign is_shift_c = (SHIFTER_control >= CMD_SLL) && (SHIFTER_control <= CMD_ROTL);
  assign accept_c   = (state_q == ST_IDLE) && is_shift_c && (SHIFTER_control != prev_cmd_q);
  assign amount_c   = M_SHIFTER ? SHAMT_W'(LUI_AMT) : shamt;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      op_q       <= CMD_NOP;
      prev_cmd_q <= CMD_NOP;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      op_q       <= op_d;
      prev_cmd_q <= SHIFTER_control;
      result_q   <= result_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
    end
  end

  // Next-state, iteration count and latched operation
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          op_d    = SHIFTER_control;
          count_d = amount_c;
          state_d = (amount_c == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        count_d = count_q - SHAMT_W'(1);
        if (count_q <= SHAMT_W'(1)) begin
          count_d = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    result_d  = result_q;
    if ((state_q == ST_IDLE) && (SHIFTER_control == CMD_LOAD)) begin
      result_d = M_SHIFTER ? src_b : src_a;
    end else if (state_q == ST_SHIFT) begin
      case (op_q)
        CMD_SLL:  result_d = {result_q[WIDTH-2:0], 1'b0};
        CMD_SRL:  result_d = {1'b0, result_q[WIDTH-1:1]};
        CMD_SRA:  result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
        CMD_ROTR: result_d = {result_q[0], result_q[WIDTH-1:1]};
        CMD_ROTL: result_d = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
        default:  result_d = result_q;
      endcase
    end
    busy_d    = (state_d == ST_SHIFT);
    // Completion after shifting pulses on the edge entering DONE. A zero-amount
    // command enters DONE straight from IDLE with done still low, and pulses
    // on the following edge instead (done_q low while in DONE marks that case).
    done_d    = ((state_q == ST_SHIFT) && (state_d == ST_DONE)) ||
                ((state_q == ST_DONE) && !done_q);
    illegal_d = (state_q == ST_IDLE) && (SHIFTER_control == CMD_ILL);
  end

  assign result      = result_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign illegal_cmd = illegal_q;

endmodule

// File: tb/tb_shift_executor.sv
module tb_shift_executor;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned LUI_AMT = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic [2:0]         SHIFTER_control;
  logic               M_SHIFTER;
  logic [WIDTH-1:0]   src_a;
  logic [WIDTH-1:0]   src_b;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   result;
  logic               busy;
  logic               done;
  logic               illegal_cmd;

  shift_executor #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .LUI_AMT(LUI_AMT)) dut (
    .clk(clk), .reset(reset), .SHIFTER_control(SHIFTER_control), .M_SHIFTER(M_SHIFTER),
    .src_a(src_a), .src_b(src_b), .shamt(shamt), .result(result), .busy(busy),
    .done(done), .illegal_cmd(illegal_cmd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int unsigned busy_cycles;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks  = 0;
  int          n_pass    = 0;
  int          done_cnt  = 0;
  int          ill_cnt   = 0;
  int          exp_dones = 0;
  int          exp_ill   = 0;
  int          busy_run  = 0;
  logic [31:0] model_res = 32'h0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
  endfunction

  // Reference: whole-amount shift/rotate with plain operators
  function automatic logic [31:0] model(logic [2:0] op, logic [31:0] v, int unsigned n);
    logic signed [31:0] s;
    s = v;
    case (op)
      3'b010:  return v << n;
      3'b011:  return v >> n;
      3'b100:  return 32'(s >>> n);
      3'b101:  return (n == 0) ? v : ((v >> n) | (v << (32 - n)));
      3'b110:  return (n == 0) ? v : ((v << n) | (v >> (32 - n)));
      default: return v;
    endcase
  endfunction

  // Monitor: counts busy cycles and scores each done pulse against the queue
  always @(negedge clk) begin
    if (!reset) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (illegal_cmd) ill_cnt++;
      if (done) begin
        exp_t e;
        done_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got done=1 with result 0x%08h, want no pending shift", result);
        end else begin
          e = exp_q.pop_front();
          check("shift_result", result, e.res);
          check("busy_cycles", 32'(busy_run), 32'(e.busy_cycles));
          check("busy_at_done", 32'(busy), 32'(0));
        end
        busy_run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL done_timeout: got no done within 200 cycles, want %0d pending done(s)", exp_q.size());
      exp_q.delete();
    end
    tick();
    tick();
  endtask

  task automatic do_load(logic m, logic [31:0] a, logic [31:0] b);
    M_SHIFTER = m;
    src_a = a;
    src_b = b;
    SHIFTER_control = 3'b001;
    tick();
    SHIFTER_control = 3'b000;
    model_res = m ? b : a;
    check("load", result, model_res);
  endtask

  task automatic do_shift(logic [2:0] op, logic m, logic [4:0] sh, int hold);
    int unsigned n;
    exp_t e;
    n = m ? LUI_AMT : 32'(sh);
    model_res = model(op, model_res, n);
    e.res = model_res;
    e.busy_cycles = n;
    exp_q.push_back(e);
    exp_dones++;
    M_SHIFTER = m;
    shamt = sh;
    SHIFTER_control = op;
    repeat (hold) tick();
    SHIFTER_control = 3'b000;
    wait_idle();
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    SHIFTER_control = 3'b000;
    M_SHIFTER = 1'b0;
    src_a = '0;
    src_b = '0;
    shamt = '0;
    #2;
    check("rst_result", result, 32'h0);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_illegal", 32'(illegal_cmd), 32'(0));
    @(negedge clk);
    reset = 1'b1;
    tick();

    do_load(1'b0, 32'h0000_00F0, 32'h0);
    do_shift(3'b010, 1'b0, 5'd4, 1);
    check("sll4_value", model_res, 32'h0000_0F00);

    do_load(1'b0, 32'h8000_0000, 32'h0);
    do_shift(3'b100, 1'b0, 5'd31, 1);
    do_load(1'b0, 32'h8000_0000, 32'h0);
    do_shift(3'b011, 1'b0, 5'd31, 1);

    do_load(1'b1, 32'hDEAD_BEEF, 32'h0000_1234);
    do_shift(3'b010, 1'b1, 5'd0, 1);

    do_load(1'b0, 32'hCAFE_0001, 32'h0);
    do_shift(3'b010, 1'b0, 5'd0, 1);
    do_shift(3'b010, 1'b0, 5'd0, 40);
    do_shift(3'b101, 1'b0, 5'd7, 40);

    do_load(1'b0, 32'h8000_0001, 32'h0);
    do_shift(3'b110, 1'b0, 5'd1, 1);

    // Reserved code in IDLE
    SHIFTER_control = 3'b111;
    tick();
    exp_ill++;
    check("illegal_pulse", 32'(illegal_cmd), 32'(1));
    check("illegal_result", result, model_res);
    SHIFTER_control = 3'b000;
    tick();
    check("illegal_clear", 32'(illegal_cmd), 32'(0));

    // Reset mid-shift aborts without a done pulse
    do_load(1'b0, $urandom, 32'h0);
    M_SHIFTER = 1'b0;
    shamt = 5'd10;
    SHIFTER_control = 3'b011;
    tick();
    SHIFTER_control = 3'b000;
    tick();
    tick();
    check("abort_busy_before", 32'(busy), 32'(1));
    reset = 1'b0;
    #1;
    check("abort_result", result, 32'h0);
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    tick();
    @(negedge clk);
    reset = 1'b1;
    model_res = 32'h0;
    tick();
    do_load(1'b0, 32'h1357_9BDF, 32'h0);
    do_shift(3'b010, 1'b0, 5'd3, 1);

    // Randomized commands against the reference model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_load(1'($urandom_range(0, 1)), $urandom, 32'($urandom_range(0, 16'hFFFF)));
      do_shift(3'($urandom_range(2, 6)), 1'($urandom_range(0, 3) == 0),
               5'($urandom_range(0, 31)), $urandom_range(1, 3));
    end

    repeat (5) tick();
    check("done_count", 32'(done_cnt), 32'(exp_dones));
    check("illegal_count", 32'(ill_cnt), 32'(exp_ill));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
